reg_file_sb: RTL
================

// Module: reg_file_sb
// PURPOSE
// - Parametrised register file for the pipelined MIPS core: 2 async read ports, 1 write port, r0 hardwired to 0.
// - Adds same-cycle write-to-read bypass and a per-register busy scoreboard for decode-stage hazard detection.
// - Sits in ID: read in decode, written from WB, allocated (marked busy) when an instruction issues with a destination.
// PARAMETERS
// - DATA_W      16  register width in bits
// - NUM_REGS    8   register count, power of 2, >=2; ADDR_W = $clog2(NUM_REGS) (localparam)
// - RESET_MODE  1   0: all registers reset to 0; 1: register i resets to i (r0 stays 0)
// - BYPASS_EN   1   1: write data forwarded to same-cycle reads; 0: read returns stored value only
// PORTS
// - clk         in   1       clock, all state updates on rising edge
// - rst_n       in   1       asynchronous active-low reset
// - rd_addr_a   in   ADDR_W  read port A address
// - rd_addr_b   in   ADDR_W  read port B address
// - rd_data_a   out  DATA_W  read port A data (combinational)
// - rd_data_b   out  DATA_W  read port B data (combinational)
// - wr_en       in   1       write enable (WB stage)
// - wr_addr     in   ADDR_W  write address
// - wr_data     in   DATA_W  write data
// - alloc_en    in   1       issue: mark alloc_addr busy
// - alloc_addr  in   ADDR_W  destination register being allocated
// - busy_a      out  1       source A has an outstanding write not yet available
// - busy_b      out  1       source B has an outstanding write not yet available
// - hazard      out  1       busy_a | busy_b
// BEHAVIOUR
// - Reset (async, rst_n=0): regs per RESET_MODE, all busy bits 0; outputs follow combinationally
//   (rd_data_x = reset content of rd_addr_x, busy_a=busy_b=hazard=0). Reset mid-operation overrides everything.
// - Write: at posedge, if wr_en && wr_addr!=0, reg[wr_addr] <= wr_data; writes to r0 discarded.
// - Read: zero latency. rd_addr_x==0 -> 0. Else if BYPASS_EN && wr_en && wr_addr==rd_addr_x -> wr_data.
//   Else reg[rd_addr_x]. Both ports may read the same address.
// - Scoreboard per register i>0, evaluated at posedge:
//   alloc_en && alloc_addr==i -> busy[i] <= 1 (takes priority);
//   else wr_en && wr_addr==i -> busy[i] <= 0; else hold. busy[0] constant 0.
// - Simultaneous alloc and write to same reg: busy stays 1 (new producer owns it); data still written.
// - busy_x = busy[rd_addr_x] & ~(BYPASS_EN && wr_en && wr_addr==rd_addr_x); r0 never busy.
// - Write to a non-busy register is legal (no error); alloc of an already-busy register keeps it busy.
// - No internal state beyond regs and busy bits; no FSM other than per-register 2-state busy tracker.
// STRUCTURE
// - Package mips_rf_pkg: default DATA_W/NUM_REGS, RESET_MODE encodings (RST_ZERO=0, RST_INDEX=1).
// - Sub-module reg_scoreboard (NUM_REGS, ADDR_W): busy bit vector, alloc/clear priority, busy lookups.
// - Top: storage array, reset init loop, write logic, bypass muxes, instantiates reg_scoreboard.
// TESTING
// - Reset, RESET_MODE=1: deassert rst_n, read r0..r7 -> 0,1,..,7; busy_a=busy_b=hazard=0.
// - Write r3=16'hBEEF, next cycle read A=r3 -> 16'hBEEF; write r0=16'h1234 -> r0 still reads 0.
// - Bypass: same cycle wr r5=16'h00AA, rd_addr_a=5 -> rd_data_a=16'h00AA before edge; BYPASS_EN=0 -> 5.
// - Scoreboard: alloc r2, next cycle rd_addr_b=2 -> busy_b=1,hazard=1; wr r2 -> busy_b=0 same cycle, 0 after.
// - Collision: alloc r4 and wr r4=16'h0F0F same edge -> reg=16'h0F0F, busy[4]=1 afterwards.
// - Async reset mid-run: busy r1,r6 set, regs written; pulse rst_n low between edges -> busy 0, regs = index.

Source files
------------

// File: rtl/mips_rf_pkg.sv
// Shared defaults and reset-mode encodings for the register file with scoreboard.
// Contents:
//   DEF_DATA_W, DEF_NUM_REGS : default register width and count
//   RST_ZERO, RST_INDEX      : RESET_MODE encodings (all zero / register i holds i)
//   rst_val()                : reset content of register idx under a given mode
package mips_rf_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_NUM_REGS = 8;

  localparam int unsigned RST_ZERO  = 0;
  localparam int unsigned RST_INDEX = 1;

  // r0 falls out as 0 under both modes.
  function automatic int unsigned rst_val(input int unsigned mode, input int unsigned idx);
    return (mode == RST_INDEX) ? idx : 0;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle between decode/writeback and the register file.
// master : drives read addresses, write port and allocation; sees read data and busy flags
// slave  : the register file itself
interface reg_file_sb_if import mips_rf_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = $clog2(DEF_NUM_REGS)
);

  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              alloc_en;
  logic [ADDR_W-1:0] alloc_addr;
  logic              busy_a;
  logic              busy_b;
  logic              hazard;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data_a, rd_data_b, busy_a, busy_b, hazard
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data_a, rd_data_b, busy_a, busy_b, hazard
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy tracker used for decode-stage hazard detection.
// Ports:
//   clk, rst_n                 : clock, async active-low reset (clears all busy bits)
//   i_alloc_en, i_alloc_addr   : issue marks a destination busy (wins over a same-edge clear)
//   i_wr_en, i_wr_addr         : writeback clears the busy bit of its destination
//   i_rd_addr_a, i_rd_addr_b   : source register lookups
//   i_fwd_a, i_fwd_b           : source is being bypassed this cycle, so it is not busy
//   o_busy_a, o_busy_b         : source has an outstanding write not yet available
module reg_scoreboard #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_alloc_en,
  input  logic [ADDR_W-1:0] i_alloc_addr,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  input  logic              i_fwd_a,
  input  logic              i_fwd_b,
  output logic              o_busy_a,
  output logic              o_busy_b
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_d;

  always_comb begin
    w_busy_d = r_busy;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      // A new producer owns the register even if the old one retires on the same edge.
      if (i_alloc_en && (i_alloc_addr == ADDR_W'(i))) begin
        w_busy_d[i] = 1'b1;
      end else if (i_wr_en && (i_wr_addr == ADDR_W'(i))) begin
        w_busy_d[i] = 1'b0;
      end
    end
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  assign o_busy_a = r_busy[i_rd_addr_a] & ~i_fwd_a;
  assign o_busy_b = r_busy[i_rd_addr_b] & ~i_fwd_b;

endmodule

// File: rtl/reg_file_sb.sv
// Register file for the pipelined MIPS core: two combinational read ports, one write port,
// r0 hardwired to zero, optional same-cycle write-to-read bypass, and a busy scoreboard.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : reg_file_sb_if.slave -- read addresses/data, write port, allocation,
//                busy_a/busy_b per source and hazard = busy_a | busy_b
module reg_file_sb import mips_rf_pkg::*; #(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter int unsigned RESET_MODE = RST_INDEX,
  parameter bit          BYPASS_EN  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_sb_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_live;
  logic              w_fwd_a;
  logic              w_fwd_b;
  logic [DATA_W-1:0] w_rd_data_a;
  logic [DATA_W-1:0] w_rd_data_b;
  logic              w_busy_a;
  logic              w_busy_b;

  // Writes to r0 are dropped here, so r0 keeps its reset value of zero.
  assign w_wr_live = bus.wr_en && (bus.wr_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= DATA_W'(rst_val(RESET_MODE, i));
      end
    end else if (w_wr_live) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Forwarding only ever applies to non-zero sources.
  assign w_fwd_a = BYPASS_EN && w_wr_live && (bus.wr_addr == bus.rd_addr_a);
  assign w_fwd_b = BYPASS_EN && w_wr_live && (bus.wr_addr == bus.rd_addr_b);

  always_comb begin
    w_rd_data_a = r_regs[bus.rd_addr_a];
    if (bus.rd_addr_a == '0) begin
      w_rd_data_a = '0;
    end else if (w_fwd_a) begin
      w_rd_data_a = bus.wr_data;
    end
  end

  always_comb begin
    w_rd_data_b = r_regs[bus.rd_addr_b];
    if (bus.rd_addr_b == '0) begin
      w_rd_data_b = '0;
    end else if (w_fwd_b) begin
      w_rd_data_b = bus.wr_data;
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_alloc_en   (bus.alloc_en),
    .i_alloc_addr (bus.alloc_addr),
    .i_wr_en      (bus.wr_en),
    .i_wr_addr    (bus.wr_addr),
    .i_rd_addr_a  (bus.rd_addr_a),
    .i_rd_addr_b  (bus.rd_addr_b),
    .i_fwd_a      (w_fwd_a),
    .i_fwd_b      (w_fwd_b),
    .o_busy_a     (w_busy_a),
    .o_busy_b     (w_busy_b)
  );

  assign bus.rd_data_a = w_rd_data_a;
  assign bus.rd_data_b = w_rd_data_b;
  assign bus.busy_a    = w_busy_a;
  assign bus.busy_b    = w_busy_b;
  assign bus.hazard    = w_busy_a | w_busy_b;

endmodule
